// File: rtl/lsu.sv
// Load/store unit between the core's memory stage and a PicoRV32 native bus master port.
// One access in flight; word-crossing misaligned accesses optionally become two bus beats.
module lsu #(
    parameter int MISALIGNED_SPLIT = 0,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_err_code,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // BEAT0 | first (or only) bus beat outstanding
    // BEAT1 | second beat of a word-crossing access
    // RESP  | one-cycle response pulse

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    localparam bit SPLIT_EN   = (MISALIGNED_SPLIT != 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int TW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   base_q, base_d;
    logic [7:0]    strb8_q, strb8_d;
    logic [63:0]   wd64_q, wd64_d;
    logic [31:0]   lo_q, lo_d;
    logic [TW-1:0] tcnt, tcnt_d;

    logic          mem_valid_d;
    logic [31:0]   mem_addr_d, mem_wdata_d;
    logic [3:0]    mem_wstrb_d;
    logic          rsp_valid_d, rsp_err_d;
    logic [31:0]   rsp_rdata_d;
    logic [1:0]    rsp_code_d;

    logic [3:0]    mask_in;
    logic [7:0]    strb8_in;
    logic [63:0]   wd64_in;
    logic          misaligned;
    logic          tcnt_last;
    logic [63:0]   beat_raw;

    // Shift the two-beat window down by the byte offset, then trim and extend to the access size.
    function automatic logic [31:0] load_extend(input logic [63:0] raw, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        logic [31:0] r;
        sh = raw >> {off, 3'b000};
        r  = sh[31:0];
        case (size)
            2'b00:   r = uns ? {24'h0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
            2'b01:   r = uns ? {16'h0, r[15:0]} : {{16{r[15]}}, r[15:0]};
            default: r = r;
        endcase
        return r;
    endfunction

    always_comb begin
        case (req_size)
            2'b00:   mask_in = 4'b0001;
            2'b01:   mask_in = 4'b0011;
            default: mask_in = 4'b1111;
        endcase
    end

    assign strb8_in   = {4'b0000, mask_in} << req_addr[1:0];
    assign wd64_in    = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign tcnt_last  = TIMEOUT_EN && (tcnt == TCNT_LAST);
    assign beat_raw   = (state == S_BEAT1) ? {mem_rdata, lo_q} : {32'h0, mem_rdata};

    assign req_ready  = (state == S_IDLE);
    assign mem_instr  = 1'b0;

    always_comb begin
        state_d     = state;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        base_d      = base_q;
        strb8_d     = strb8_q;
        wd64_d      = wd64_q;
        lo_d        = lo_q;
        tcnt_d      = tcnt;
        mem_valid_d = mem_valid;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_wstrb_d = mem_wstrb;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        rsp_code_d  = rsp_err_code;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    base_d  = {req_addr[31:2], 2'b00};
                    strb8_d = strb8_in;
                    wd64_d  = wd64_in;
                    if (req_size == 2'b11) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_code_d  = ERR_SIZE;
                    end else if (!SPLIT_EN && misaligned) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_code_d  = ERR_MISALIGN;
                    end else begin
                        state_d     = S_BEAT0;
                        tcnt_d      = '0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wstrb_d = req_we ? strb8_in[3:0] : 4'b0000;
                        mem_wdata_d = req_we ? wd64_in[31:0] : 32'h0;
                    end
                end
            end
            S_BEAT0, S_BEAT1: begin
                if (mem_ready) begin
                    if ((state == S_BEAT0) && (strb8_q[7:4] != 4'b0000)) begin
                        // mem_valid stays high across the beat boundary
                        state_d     = S_BEAT1;
                        lo_d        = mem_rdata;
                        tcnt_d      = '0;
                        mem_addr_d  = base_q + 32'd4;
                        mem_wstrb_d = we_q ? strb8_q[7:4] : 4'b0000;
                        mem_wdata_d = we_q ? wd64_q[63:32] : 32'h0;
                    end else begin
                        state_d     = S_RESP;
                        mem_valid_d = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_code_d  = ERR_NONE;
                        rsp_rdata_d = we_q ? 32'h0 : load_extend(beat_raw, off_q, size_q, uns_q);
                    end
                end else if (tcnt_last) begin
                    state_d     = S_RESP;
                    mem_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_code_d  = ERR_TIMEOUT;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            base_q       <= '0;
            strb8_q      <= '0;
            wd64_q       <= '0;
            lo_q         <= '0;
            tcnt         <= '0;
            mem_valid    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_err_code <= ERR_NONE;
        end else begin
            state        <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            base_q       <= base_d;
            strb8_q      <= strb8_d;
            wd64_q       <= wd64_d;
            lo_q         <= lo_d;
            tcnt         <= tcnt_d;
            mem_valid    <= mem_valid_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            mem_wstrb    <= mem_wstrb_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_err      <= rsp_err_d;
            rsp_err_code <= rsp_code_d;
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Parametrised load/store unit sitting between the core's execute/memory stage and the PicoRV32 native memory interface. Accepts one byte, halfword or word access at a time. Generates byte-lane strobes and lane-shifted write data, and sign- or zero-extends read data. Optionally splits word-crossing misaligned accesses into two bus beats, and aborts stalled beats with a timeout error.

## Interface

Parameters:
- MISALIGNED_SPLIT, default 0: 0 = any access whose address is not a multiple of its size is an error; 1 = misaligned accesses are performed, split into two beats when they cross a word.
- TIMEOUT_CYCLES, default 255: abort a beat after this many cycles with mem_valid=1 and mem_ready=0; 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  access request
- req_ready  out  1  high only in IDLE; an access is accepted on req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse; there is no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access failed
- rsp_err_code  out  2  00 none, 01 misaligned, 10 timeout, 11 bad size
- mem_valid, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]  out  PicoRV32 native master; mem_instr is tied 0
- mem_ready  in  1, mem_rdata  in  32  PicoRV32 native slave response

## Operation

- States: IDLE, BEAT0, BEAT1, RESP.
- On accept, latch all req_* fields.
  - off = addr[1:0].
  - mask = 0001 / 0011 / 1111 for byte / half / word.
  - strb8 = mask << off (8 bits).
  - wd64 = {32'b0, wdata} << (8*off).
  - base = addr & ~3.
- Decode checks, in priority order:
  - size 11 → code 11.
  - If MISALIGNED_SPLIT=0 and addr is not a multiple of the size → code 01.
  - On either error: IDLE → RESP, no bus activity.
- IDLE → BEAT0 otherwise. BEAT0 drives:
  - mem_addr = base;
  - mem_wstrb = we ? strb8[3:0] : 0000;
  - mem_wdata = we ? wd64[31:0] : 0.
- BEAT0 completes on mem_valid && mem_ready:
  - lo ← mem_rdata.
  - If strb8[7:4] != 0 → BEAT1, else → RESP.
  - Crossing is only possible with MISALIGNED_SPLIT=1.
- BEAT1 drives:
  - mem_addr = base + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000);
  - mem_wstrb = we ? strb8[7:4] : 0000;
  - mem_wdata = wd64[63:32] for stores.
  - On completion: hi ← mem_rdata, → RESP.
- Load result:
  - r = ({hi, lo} >> (8*off))[31:0], with hi = 0 for single-beat accesses;
  - truncate to size, then sign/zero-extend per req_unsigned.
- Timeout: the counter clears on entering each beat and increments every beat cycle with mem_ready=0. When it reaches TIMEOUT_CYCLES:
  - drop mem_valid;
  - → RESP with code 10.
  - A completed BEAT0 store is not rolled back.
- RESP: rsp_valid=1 for exactly one cycle, then → IDLE.

## Timing

- All outputs except req_ready are registered. req_ready = (state == IDLE).
- Reset values:
  - mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb = 0;
  - rsp_valid, rsp_rdata, rsp_err, rsp_err_code = 0;
  - state IDLE, so req_ready = 1.
- Zero-wait, single-beat access:
  - accept at edge 0;
  - mem_valid high in cycle 1, with mem_ready sampled high;
  - rsp_valid in cycle 2;
  - req_ready in cycle 3.
  - Minimum issue interval is 3 cycles.
- Bus stability:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are stable from beat entry until mem_ready is sampled.
  - BEAT0 → BEAT1 keeps mem_valid high; addr/strb/wdata change in the following cycle.
  - mem_valid is low in RESP and IDLE.
- Decode error: accept at edge 0, rsp_valid in cycle 1.
- Timeout with TIMEOUT_CYCLES=N: mem_valid is high for N cycles of the beat, and rsp_valid follows in the next cycle.
- mem_ready while mem_valid=0 is ignored.
- Asynchronous reset mid-access: all outputs return to reset values immediately, and no response is issued.

## Test plan

- Word store 0xDEADBEEF at 0x100, mem_ready tied 1 → one beat: mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF; rsp_valid in cycle 2, rsp_err 0.
- lb at 0x103 (signed) with mem_rdata 0x80xxxxxx → wstrb 0000, rsp_rdata 0xFFFFFF80. The same access with lbu → 0x00000080.
- sh 0x1234 at 0x102 → wstrb 1100, wdata 0x12340000. lh at 0x101 with MISALIGNED_SPLIT=0 → no mem_valid, rsp_err 1, code 01.
- MISALIGNED_SPLIT=1, lw at 0xFFFFFFFE, beats returning 0xAABBxxxx then 0xxxxxCCDD → addrs 0xFFFFFFFC then 0x00000000, rsp_rdata 0xCCDDAABB. sw 0x11223344 at 0x203 → beat 0x200 wstrb 1000 wdata 0x44000000, then beat 0x204 wstrb 0111 wdata 0x00112233.
- TIMEOUT_CYCLES=4, mem_ready held 0 → mem_valid high exactly 4 cycles, then rsp_err 1, code 10; req_ready returns. req_size 11 → code 11 with no bus activity.
- Assert reset_n low while mem_valid=1 in BEAT1 → mem_valid drops immediately, no rsp_valid. After release, req_ready=1 and the next access is correct.
